// File: rtl/rx_frame_sync_if.sv
// ---------------------------------------------------------------------------
// rx_frame_sync_if
//   Bundles the recovered-bit input and the deframed byte stream of
//   rx_frame_sync.
//
//   Handshake: rx_bit is consumed on every clk_1M024 edge where rx_bit_valid
//   is high. The byte stream has no ready signal. data_tvalid is a one-cycle
//   strobe, and the sink must take the byte in that cycle. data_tuser and
//   data_tlast are only meaningful while data_tvalid is high.
//
//   master : bit source / byte sink (drives rx_bit, rx_bit_valid)
//   slave  : the deframer (drives the data_* stream and the status outputs)
// ---------------------------------------------------------------------------
interface rx_frame_sync_if;
    logic        rx_bit;
    logic        rx_bit_valid;
    logic [7:0]  data_tdata;
    logic        data_tvalid;
    logic        data_tlast;
    logic        data_tuser;
    logic        locked;
    logic        inverted;
    logic [15:0] frame_cnt;

    modport master (
        output rx_bit, rx_bit_valid,
        input  data_tdata, data_tvalid, data_tlast, data_tuser,
        input  locked, inverted, frame_cnt
    );

    modport slave (
        input  rx_bit, rx_bit_valid,
        output data_tdata, data_tvalid, data_tlast, data_tuser,
        output locked, inverted, frame_cnt
    );
endinterface

// File: rtl/rx_frame_sync.sv
// ---------------------------------------------------------------------------
// rx_frame_sync
//   Receive-side deframer. It hunts for the sync word in the recovered bit
//   stream and resolves BPSK polarity from whether the sync word is seen
//   true or inverted. It then packs PAYLOAD_BYTES payload bytes MSB-first
//   onto a strobe-only byte stream. A flywheel re-checks the sync word at
//   each expected frame boundary and drops lock after MISS_LIMIT
//   consecutive misses.
//
// Ports
//   clk_1M024    : bit-rate clock
//   rst_n_1M024  : asynchronous reset, active low
//   bus          : rx_frame_sync_if.slave
//                  in : rx_bit, rx_bit_valid
//                  out: data_tdata/tvalid/tlast/tuser, locked, inverted,
//                       frame_cnt
//   o_dbg_state  : current FSM state (HUNT=0, PAYLOAD=1, CHECK=2)
// ---------------------------------------------------------------------------
module rx_frame_sync #(
    parameter int          SYNC_LEN      = 32,
    parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
    parameter int          PAYLOAD_BYTES = 64,
    parameter int          MAX_ERR       = 2,
    parameter int          MISS_LIMIT    = 3
) (
    input  logic                 clk_1M024,
    input  logic                 rst_n_1M024,
    rx_frame_sync_if.slave       bus,
    output logic [1:0]           o_dbg_state
);

    localparam int DW = $clog2(SYNC_LEN + 1);
    localparam int CW = $clog2(SYNC_LEN);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [SYNC_LEN-1:0] SYNC      = SYNC_WORD[SYNC_LEN-1:0];
    localparam logic [DW-1:0]       ERR_LIM   = DW'(MAX_ERR);
    localparam logic [7:0]          LAST_BYTE = 8'(PAYLOAD_BYTES - 1);
    localparam logic [CW-1:0]       CHK_LAST  = CW'(SYNC_LEN - 1);
    localparam logic [MW-1:0]       MISS_MAX  = MW'(MISS_LIMIT);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    function automatic logic [DW-1:0] popcnt(input logic [SYNC_LEN-1:0] v);
        logic [DW-1:0] c;
        c = '0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            c = c + DW'(v[i]);
        end
        return c;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SYNC_LEN-2:0] r_sr;
    logic [6:0]          r_byte;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_byte_cnt;
    logic [CW-1:0]       r_chk_cnt;
    logic [MW-1:0]       r_miss;
    logic [7:0]          r_tdata;
    logic                r_tvalid;
    logic                r_tlast;
    logic                r_tuser;
    logic                r_locked;
    logic                r_inverted;
    logic [15:0]         r_frame_cnt;

    logic [SYNC_LEN-1:0] w_win;
    logic [DW-1:0]       w_d0;
    logic [DW-1:0]       w_d1;
    logic [7:0]          w_byte;
    logic [MW-1:0]       w_miss_inc;
    logic                w_acquire;
    logic                w_acq_inv;
    logic                w_byte_done;
    logic                w_chk_done;
    logic                w_chk_ok;
    logic                w_drop;

    // The window always includes the incoming bit, so a match is recognised
    // on the same edge that clocks the last sync bit in.
    assign w_win      = {r_sr, bus.rx_bit};
    assign w_d0       = popcnt(w_win ^ SYNC);
    assign w_d1       = popcnt(w_win ^ ~SYNC);
    assign w_byte     = {r_byte, bus.rx_bit ^ r_inverted};
    assign w_miss_inc = r_miss + MW'(1);

    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acquire   = 1'b0;
        w_acq_inv   = 1'b0;
        w_byte_done = 1'b0;
        w_chk_done  = 1'b0;
        w_chk_ok    = 1'b0;
        w_drop      = 1'b0;
        if (bus.rx_bit_valid) begin
            case (r_state)
                S_HUNT: begin
                    // True polarity wins when both distances qualify.
                    if (w_d0 <= ERR_LIM) begin
                        w_acquire   = 1'b1;
                        w_state_nxt = S_PAYLOAD;
                    end else if (w_d1 <= ERR_LIM) begin
                        w_acquire   = 1'b1;
                        w_acq_inv   = 1'b1;
                        w_state_nxt = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_byte_done = 1'b1;
                        if (r_byte_cnt == LAST_BYTE) begin
                            w_state_nxt = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (r_chk_cnt == CHK_LAST) begin
                        w_chk_done = 1'b1;
                        // The check uses the locked polarity only. An
                        // opposite-polarity word counts as a miss.
                        w_chk_ok   = r_inverted ? (w_d1 <= ERR_LIM) : (w_d0 <= ERR_LIM);
                        if (!w_chk_ok && (w_miss_inc >= MISS_MAX)) begin
                            w_drop      = 1'b1;
                            w_state_nxt = S_HUNT;
                        end else begin
                            w_state_nxt = S_PAYLOAD;
                        end
                    end
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            r_sr        <= '0;
            r_byte      <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_chk_cnt   <= '0;
            r_miss      <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_locked    <= 1'b0;
            r_inverted  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
            if (bus.rx_bit_valid) begin
                // The raw (uncorrected) bit stream always feeds the sync
                // window, whatever the state.
                r_sr <= w_win[SYNC_LEN-2:0];
                if (w_acquire) begin
                    r_locked    <= 1'b1;
                    r_inverted  <= w_acq_inv;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_miss      <= '0;
                    r_bit_cnt   <= '0;
                    r_byte_cnt  <= '0;
                end
                if (r_state == S_PAYLOAD) begin
                    r_byte    <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_chk_cnt <= '0;
                    if (w_byte_done) begin
                        r_tdata    <= w_byte;
                        r_tvalid   <= 1'b1;
                        r_tuser    <= (r_byte_cnt == 8'd0);
                        r_tlast    <= (r_byte_cnt == LAST_BYTE);
                        r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? 8'd0 : r_byte_cnt + 8'd1;
                    end
                end
                if (r_state == S_CHECK) begin
                    r_chk_cnt <= r_chk_cnt + CW'(1);
                    if (w_chk_done) begin
                        r_chk_cnt <= '0;
                        r_miss    <= w_chk_ok ? '0 : w_miss_inc;
                        if (w_drop) begin
                            // Polarity is kept until the next acquisition.
                            r_locked <= 1'b0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.data_tdata  = r_tdata;
    assign bus.data_tvalid = r_tvalid;
    assign bus.data_tlast  = r_tlast;
    assign bus.data_tuser  = r_tuser;
    assign bus.locked      = r_locked;
    assign bus.inverted    = r_inverted;
    assign bus.frame_cnt   = r_frame_cnt;
    assign o_dbg_state     = r_state;

endmodule
